// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - frame/button/collision inputs and game status outputs of game_flow_ctrl
// Optional macro GAME_PAUSE_EN adds pause_btn and paused.
interface game_flow_ctrl_if;
  logic       frame_tick;
  logic       start_btn;
  logic       collision;
  logic       obj_wrap;
`ifdef GAME_PAUSE_EN
  logic       pause_btn;
  logic       paused;
`endif
  logic       menu_screen;
  logic       player_won;
  logic       player_lost;
  logic       reset_obj_count;
  logic [1:0] level;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] state;

  // Button/collision/video side: drives the events, observes game status.
  modport master (
    output frame_tick,
    output start_btn,
    output collision,
    output obj_wrap,
`ifdef GAME_PAUSE_EN
    output pause_btn,
    input  paused,
`endif
    input  menu_screen,
    input  player_won,
    input  player_lost,
    input  reset_obj_count,
    input  level,
    input  lives,
    input  score,
    input  state
  );

  // Sequencer side.
  modport slave (
    input  frame_tick,
    input  start_btn,
    input  collision,
    input  obj_wrap,
`ifdef GAME_PAUSE_EN
    input  pause_btn,
    output paused,
`endif
    output menu_screen,
    output player_won,
    output player_lost,
    output reset_obj_count,
    output level,
    output lives,
    output score,
    output state
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - obstacle game sequencer: level, lives, score and frame timers
// Optional macro GAME_PAUSE_EN adds a PAUSED state (7) driven by pause_btn edges.
module game_flow_ctrl #(
  parameter int NUM_LEVELS       = 3,     // 1..4, finishing level NUM_LEVELS-1 wins
  parameter int START_LIVES      = 3,     // 1..3
  parameter int LEVEL_FRAMES     = 1500,  // < 2048
  parameter int COUNTDOWN_FRAMES = 180,   // 1..2047
  parameter int RESULT_FRAMES    = 240    // 1..2047
) (
  input logic         clk,
  input logic         reset,
  game_flow_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_HIT       = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_WON       = 3'd5,
    ST_LOST      = 3'd6,
    ST_PAUSED    = 3'd7
  } state_t;

  localparam logic [1:0]  LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
  localparam logic [10:0] LEVEL_LAST = 11'(LEVEL_FRAMES - 1);
  localparam logic [10:0] CD_LOAD    = 11'(COUNTDOWN_FRAMES - 1);
  localparam logic [10:0] RES_LOAD   = 11'(RESULT_FRAMES - 1);

  state_t      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [10:0] lvl_timer_q, lvl_timer_d;
  logic [10:0] cd_timer_q, cd_timer_d;
  logic [10:0] res_timer_q, res_timer_d;
  logic        start_q;
  logic        start_edge;
  logic [7:0]  score_inc;
  logic        menu_q, won_q, lost_q, roc_q;
`ifdef GAME_PAUSE_EN
  logic        pause_q;
  logic        pause_edge;
  logic        paused_q;
`endif

  assign start_edge = bus.start_btn & ~start_q;
  // Score saturates rather than wrapping so a long game never shows a low score.
  assign score_inc  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
`ifdef GAME_PAUSE_EN
  assign pause_edge = bus.pause_btn & ~pause_q;
`endif

  // State, counters and registered Moore flags; flags decode the next state so they move with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_MENU;
      level_q     <= 2'd0;
      lives_q     <= LIVES_INIT;
      score_q     <= 8'd0;
      lvl_timer_q <= 11'd0;
      cd_timer_q  <= 11'd0;
      res_timer_q <= 11'd0;
      start_q     <= 1'b0;
      menu_q      <= 1'b1;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      roc_q       <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause_q     <= 1'b0;
      paused_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      lvl_timer_q <= lvl_timer_d;
      cd_timer_q  <= cd_timer_d;
      res_timer_q <= res_timer_d;
      start_q     <= bus.start_btn;
      menu_q      <= (state_d == ST_MENU);
      won_q       <= (state_d == ST_WON);
      lost_q      <= (state_d == ST_LOST);
      roc_q       <= (state_d == ST_COUNTDOWN) || (state_d == ST_HIT) ||
                     (state_d == ST_LEVEL_UP);
`ifdef GAME_PAUSE_EN
      pause_q     <= bus.pause_btn;
      paused_q    <= (state_d == ST_PAUSED);
`endif
    end
  end

  // Next-state and counter update; everything holds unless a state arm changes it.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    lives_d     = lives_q;
    score_d     = score_q;
    lvl_timer_d = lvl_timer_q;
    cd_timer_d  = cd_timer_q;
    res_timer_d = res_timer_q;

    case (state_q)
      ST_MENU: begin
        if (start_edge) begin
          state_d     = ST_COUNTDOWN;
          level_d     = 2'd0;
          lives_d     = LIVES_INIT;
          score_d     = 8'd0;
          lvl_timer_d = 11'd0;
          cd_timer_d  = CD_LOAD;
        end
      end

      // Collision, obstacle wraps and start are deliberately ignored while holding.
      ST_COUNTDOWN: begin
        if (bus.frame_tick) begin
          if (cd_timer_q == 11'd0) begin
            state_d = ST_PLAY;
          end else begin
            cd_timer_d = cd_timer_q - 11'd1;
          end
        end
      end

      // Collision wins over everything, including an obstacle wrap and level completion.
      ST_PLAY: begin
        if (bus.collision) begin
          if (lives_q == 2'd1) begin
            state_d     = ST_LOST;
            lives_d     = 2'd0;
            res_timer_d = RES_LOAD;
          end else begin
            state_d = ST_HIT;
            lives_d = lives_q - 2'd1;
          end
        end
`ifdef GAME_PAUSE_EN
        // Pausing freezes progress on the entry cycle too.
        else if (pause_edge) begin
          state_d = ST_PAUSED;
        end
`endif
        else begin
          if (bus.obj_wrap) begin
            score_d = score_inc;
          end
          if (bus.frame_tick) begin
            if (lvl_timer_q == LEVEL_LAST) begin
              if (level_q == LAST_LEVEL) begin
                state_d     = ST_WON;
                res_timer_d = RES_LOAD;
              end else begin
                state_d = ST_LEVEL_UP;
              end
            end else begin
              lvl_timer_d = lvl_timer_q + 11'd1;
            end
          end
        end
      end

      // Level progress survives a hit; only the countdown restarts.
      ST_HIT: begin
        state_d    = ST_COUNTDOWN;
        cd_timer_d = CD_LOAD;
      end

      ST_LEVEL_UP: begin
        state_d     = ST_COUNTDOWN;
        level_d     = level_q + 2'd1;
        lvl_timer_d = 11'd0;
        cd_timer_d  = CD_LOAD;
      end

      // Result screens keep level/lives/score on display until timeout or start.
      ST_WON, ST_LOST: begin
        if (start_edge) begin
          state_d = ST_MENU;
        end else if (bus.frame_tick) begin
          if (res_timer_q == 11'd0) begin
            state_d = ST_MENU;
          end else begin
            res_timer_d = res_timer_q - 11'd1;
          end
        end
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        if (start_edge) begin
          state_d = ST_MENU;
        end else if (pause_edge) begin
          state_d    = ST_COUNTDOWN;
          cd_timer_d = CD_LOAD;
        end
      end
`endif

      // Reserved encoding falls back to the menu.
      default: begin
        state_d = ST_MENU;
      end
    endcase
  end

  assign bus.menu_screen     = menu_q;
  assign bus.player_won      = won_q;
  assign bus.player_lost     = lost_q;
  assign bus.reset_obj_count = roc_q;
  assign bus.level           = level_q;
  assign bus.lives           = lives_q;
  assign bus.score           = score_q;
  assign bus.state           = state_q;
`ifdef GAME_PAUSE_EN
  assign bus.paused          = paused_q;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;
  localparam logic [2:0] M = 3'd0, C = 3'd1, P = 3'd2, H = 3'd3, U = 3'd4, W = 3'd5, L = 3'd6;

  logic clk = 1'b0;
  logic reset = 1'b0;

  game_flow_ctrl_if bus();

  game_flow_ctrl #(
    .NUM_LEVELS      (2),
    .START_LIVES     (2),
    .LEVEL_FRAMES    (10),
    .COUNTDOWN_FRAMES(3),
    .RESULT_FRAMES   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       col;
    logic       wrap;
    logic       tick;
    logic [2:0] st;
    logic [1:0] lvl;
    logic [1:0] lives;
    logic [7:0] score;
  } vec_t;

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [2:0] e_st;
  logic [1:0] e_lvl, e_lives;
  logic [7:0] e_score;

  function automatic vec_t mk(input logic s, co, wr, tk, input logic [2:0] st,
                              input logic [1:0] lv, li, input logic [7:0] sc);
    vec_t r;
    r.start = s; r.col = co; r.wrap = wr; r.tick = tk;
    r.st = st; r.lvl = lv; r.lives = li; r.score = sc;
    return r;
  endfunction

  function automatic logic [18:0] pack_exp(input logic [2:0] s, input logic [1:0] lv, li,
                                           input logic [7:0] sc);
    return {s, (s == M), (s == W), (s == L), ((s == C) || (s == H) || (s == U)), lv, li, sc};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.state, bus.menu_screen, bus.player_won, bus.player_lost,
            bus.reset_obj_count, bus.level, bus.lives, bus.score};
  endfunction

  task automatic push_exp(input string name);
    exp_t e;
    e.name = name;
    e.v    = pack_exp(e_st, e_lvl, e_lives, e_score);
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [18:0] got;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow: no expected entry queued");
      return;
    end
    e   = sb.pop_front();
    got = dut_out();
    if (got !== e.v) begin
      n_fail++;
      $display("FAIL %s @%0t: got st=%0d flags(menu,won,lost,roc)=%b lvl=%0d lives=%0d score=%0d, required st=%0d flags=%b lvl=%0d lives=%0d score=%0d",
               e.name, $time, got[18:16], got[15:12], got[11:10], got[9:8], got[7:0],
               e.v[18:16], e.v[15:12], e.v[11:10], e.v[9:8], e.v[7:0]);
    end
  endtask

  task automatic cyc(input logic s, co, wr, tk, input string name);
    bus.start_btn  = s;
    bus.collision  = co;
    bus.obj_wrap   = wr;
    bus.frame_tick = tk;
    push_exp(name);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, name);
  endtask

  // Countdown of 3 frame ticks (4 clk apart); PLAY on the third.
  task automatic countdown();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) e_st = P;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "countdown_tick");
      idle(3, "countdown_gap");
    end
  endtask

  // n PLAY frame ticks that stay in PLAY.
  task automatic play_ticks(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, name);
      idle(3, name);
    end
  endtask

  // Result screen held for 4 ticks, MENU on the fourth.
  task automatic result_timeout(input string name);
    for (int k = 0; k < 4; k++) begin
      idle(3, name);
      if (k == 3) e_st = M;
      cyc(1'b0, 1'b0, 1'b0, 1'b1, name);
    end
  endtask

  task automatic new_game();
    e_st = C; e_lvl = 2'd0; e_lives = 2'd2; e_score = 8'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "new_game_start");
    countdown();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef GAME_PAUSE_EN
  initial bus.pause_btn = 1'b0;
`endif

  initial begin
    bus.start_btn  = 1'b0;
    bus.collision  = 1'b0;
    bus.obj_wrap   = 1'b0;
    bus.frame_tick = 1'b0;

    // Stimulus table: reset idle, start at clk 5, countdown ignoring events, enter PLAY.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, M, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, C, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, C, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, C, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, C, 0, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, C, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, C, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, C, 0, 2, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, C, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, P, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, P, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, P, 0, 2, 0));

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    e_st = M; e_lvl = 2'd0; e_lives = 2'd2; e_score = 8'd0;
    push_exp("reset_async");
    check_pop();
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      e_st = tbl[i].st; e_lvl = tbl[i].lvl; e_lives = tbl[i].lives; e_score = tbl[i].score;
      cyc(tbl[i].start, tbl[i].col, tbl[i].wrap, tbl[i].tick, $sformatf("table_%0d", i));
    end

    // Game 1, level 0: 10 ticks with 3 obstacle wraps, then LEVEL_UP.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "l0_tick");
      if (i == 1 || i == 3 || i == 5) e_score = e_score + 8'd1;
      cyc(1'b0, 1'b0, (i == 1 || i == 3 || i == 5), 1'b0, "l0_wrap");
      idle(2, "l0_idle");
    end
    e_st = U;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "level_up");
    e_st = C; e_lvl = 2'd1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "level_up_to_countdown");
    countdown();
    // Level 1 (last): 10 ticks win, result held 4 ticks.
    play_ticks(9, "l1_tick");
    e_st = W;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "won_entry");
    result_timeout("won_hold");
    idle(2, "menu_after_won");

    // Game 2: collision at tick 6 keeps level progress.
    new_game();
    play_ticks(6, "g2_l0_tick");
    e_st = H; e_lives = 2'd1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, "hit_entry");
    e_st = C;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "hit_to_countdown");
    countdown();
    play_ticks(3, "g2_l0_resume");
    e_st = U;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "g2_level_up_after_4");
    e_st = C; e_lvl = 2'd1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "g2_countdown");
    countdown();
    play_ticks(2, "g2_l1_tick");
    e_st = L; e_lives = 2'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "lost_last_life");
    idle(1, "lost_hold");
    e_st = M;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "lost_start_to_menu");
    idle(1, "menu_release");

    // Game 3: collision and final level tick on the same clk.
    e_st = C; e_lvl = 2'd0; e_lives = 2'd2; e_score = 8'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "g3_start");
    countdown();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "g3_l0_tick");
      if (i == 0) e_score = 8'd1;
      cyc(1'b0, 1'b0, (i == 0), 1'b0, "g3_l0_wrap");
      idle(2, "g3_l0_idle");
    end
    e_st = H; e_lives = 2'd1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, "col_beats_level_tick");
    e_st = C;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "g3_hit_to_countdown");
    countdown();
    e_st = U;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "g3_level_progress_kept");
    e_st = C; e_lvl = 2'd1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "g3_countdown");
    countdown();
    play_ticks(9, "g3_l1_tick");
    e_st = L; e_lives = 2'd0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, "col_beats_win_tick");
    result_timeout("lost_timeout");

    // Game 4: score saturation, then reset mid-PLAY.
    new_game();
    for (int i = 0; i < 260; i++) begin
      if (e_score != 8'hFF) e_score = e_score + 8'd1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "score_saturate");
    end
    #2 reset = 1'b1;
    #1;
    e_st = M; e_lvl = 2'd0; e_lives = 2'd2; e_score = 8'd0;
    push_exp("reset_mid_play_async");
    check_pop();
    @(posedge clk);
    #1 reset = 1'b0;
    push_exp("reset_mid_play_held");
    check_pop();
    idle(2, "menu_after_reset");

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
